inst_fetcher: RTL and testbench

INST_FETCHER -- requirements
Module: inst_fetcher

---
 rtl/inst_fetcher.sv | 140 ++++++++++++++
 tb/tb_inst_fetcher.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetcher: assembles 32-bit little-endian instructions from a byte-wide memory port.
// Latency: 5 cycles per instruction from memory (2 on a cache hit with ICACHE_EN); stall holds the instruction in DONE.
// Backpressure: stall freezes PC and output; mem_ready=0 holds the request; branch_taken overrides everything.
`ifndef addrWidth
`define addrWidth 32
`endif
`ifndef instWidth
`define instWidth 32
`endif

module inst_fetcher #(
    parameter int ICACHE_LINES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [`addrWidth-1:0]  branch_target,
    output logic                   mem_req,
    output logic [`addrWidth-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [7:0]             mem_data,
    output logic                   inst_valid,
    output logic [`instWidth-1:0]  inst_output,
    output logic [`addrWidth-1:0]  pc_output,
    output logic                   if_busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [`addrWidth-1:0] pc_q, pc_d;
    logic [1:0]            k_q, k_d;
    logic [`instWidth-1:0] inst_q, inst_d;
    logic                  cache_hit;
    logic [`instWidth-1:0] hit_dat;

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = `addrWidth - 2 - IDX_W;

    logic [`instWidth-1:0] line_dat_q [ICACHE_LINES];
    logic [TAG_W-1:0]      line_tag_q [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] line_vld_q;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  line_fill;

    assign idx       = pc_q[IDX_W+1:2];
    assign tag       = pc_q[`addrWidth-1:IDX_W+2];
    assign cache_hit = line_vld_q[idx] && (line_tag_q[idx] == tag);
    assign hit_dat   = line_dat_q[idx];
    // Fill only on a completed miss; a branch on the last byte discards it.
    assign line_fill = (state_q == FETCH) && !cache_hit && mem_ready
                       && (k_q == 2'd3) && !branch_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_vld_q <= '0;
        end else if (line_fill) begin
            line_vld_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_fill) begin
            line_dat_q[idx] <= inst_d;
            line_tag_q[idx] <= tag;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_dat   = '0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        k_d     = k_q;
        inst_d  = inst_q;
        if (branch_taken) begin
            state_d = FETCH;
            pc_d    = branch_target & {{(`addrWidth-2){1'b1}}, 2'b00};
            k_d     = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!stall) begin
                        state_d = FETCH;
                        k_d     = 2'd0;
                    end
                end
                FETCH: begin
                    if (cache_hit) begin
                        inst_d  = hit_dat;
                        state_d = DONE;
                    end else if (mem_ready) begin
                        inst_d[{k_q, 3'b000} +: 8] = mem_data;
                        k_d = k_q + 2'd1;
                        if (k_q == 2'd3) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (!stall) begin
                        pc_d    = pc_q + `addrWidth'(4);
                        state_d = FETCH;
                        k_d     = 2'd0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            k_q     <= 2'd0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            k_q     <= k_d;
            inst_q  <= inst_d;
        end
    end

    assign mem_req     = (state_q == FETCH) && !cache_hit;
    assign mem_addr    = pc_q + `addrWidth'(k_q);
    assign inst_valid  = (state_q == DONE);
    assign inst_output = inst_q;
    assign pc_output   = pc_q;
    assign if_busy     = (state_q != DONE);

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed and randomized checks of inst_fetcher against a byte-memory / expected-PC model.
module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_data;
    logic        inst_valid;
    logic [31:0] inst_output;
    logic [31:0] pc_output;
    logic        if_busy;

    logic [7:0]  mem [512];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr[8:0]];

    inst_fetcher #(.ICACHE_LINES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ready     (mem_ready),
        .mem_data      (mem_data),
        .inst_valid    (inst_valid),
        .inst_output   (inst_output),
        .pc_output     (pc_output),
        .if_busy       (if_busy)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] a1, a2, a3;
        a1 = a + 32'd1;
        a2 = a + 32'd2;
        a3 = a + 32'd3;
        return {mem[a3[8:0]], mem[a2[8:0]], mem[a1[8:0]], mem[a[8:0]]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int c;
        c = 0;
        while (!inst_valid && c < 20) begin
            tick();
            c++;
        end
        chk(tag, 32'(inst_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_pc;
        logic        v, b, s;
        logic [31:0] t;
        int          deliveries;

        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;

        // Reset values
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_output", inst_output, 32'd0);
        chk("rst_pc_output", pc_output, 32'd0);
        chk("rst_if_busy", 32'(if_busy), 32'd1);

        // First instruction after reset release
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("idle_no_req", 32'(mem_req), 32'd0);
        tick();
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'd0);
        tick(); tick(); tick();
        chk("not_yet_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("first_valid", 32'(inst_valid), 32'd1);
        chk("first_inst", inst_output, 32'h00500013);
        chk("first_pc", pc_output, 32'd0);
        chk("first_busy", 32'(if_busy), 32'd0);
        tick();
        chk("next_addr", mem_addr, 32'd4);
        chk("next_req", 32'(mem_req), 32'd1);
        chk("next_valid", 32'(inst_valid), 32'd0);

        // Memory wait states at byte 2
        tick(); tick();
        chk("k2_addr", mem_addr, 32'd6);
        mem_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wait_addr", mem_addr, 32'd6);
            chk("wait_req", 32'(mem_req), 32'd1);
            chk("wait_busy", 32'(if_busy), 32'd1);
            chk("wait_valid", 32'(inst_valid), 32'd0);
        end
        mem_ready = 1'b1;
        tick(); tick();
        chk("wait_done_valid", 32'(inst_valid), 32'd1);
        chk("wait_done_pc", pc_output, 32'd4);
        chk("wait_done_inst", inst_output, word_at(32'd4));

        // Stall held in DONE at pc 8
        tick();
        tick(); tick(); tick(); tick();
        chk("pc8_valid", 32'(inst_valid), 32'd1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_pc", pc_output, 32'd8);
            chk("stall_inst", inst_output, word_at(32'd8));
            chk("stall_req", 32'(mem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        chk("unstall_addr", mem_addr, 32'd12);
        chk("unstall_req", 32'(mem_req), 32'd1);

        // Branch on the 4th byte discards the instruction
        tick(); tick(); tick();
        branch_taken = 1'b1;
        branch_target = 32'h103;
        tick();
        branch_taken = 1'b0;
        chk("br4_valid", 32'(inst_valid), 32'd0);
        chk("br4_addr", mem_addr, 32'h100);
        chk("br4_req", 32'(mem_req), 32'd1);
        tick(); tick(); tick();
        chk("br4_k3_valid", 32'(inst_valid), 32'd0);
        tick();
        chk("br_tgt_pc", pc_output, 32'h100);
        chk("br_tgt_inst", inst_output, word_at(32'h100));

        // PC wrap at the top of the address space
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0;
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        tick(); tick(); tick(); tick();
        chk("wrap_pc", pc_output, 32'hFFFF_FFFC);
        chk("wrap_inst", inst_output, word_at(32'hFFFF_FFFC));
        tick();
        chk("wrap_next_addr", mem_addr, 32'd0);

        // Asynchronous reset mid-fetch
        branch_taken = 1'b1;
        branch_target = 32'h40;
        tick();
        branch_taken = 1'b0;
        tick();
        chk("mid_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_busy", 32'(if_busy), 32'd1);

        // Stall in IDLE, then branch overrides it
        @(negedge clk);
        rst = 1'b1;
        stall = 1'b1;
        tick(); tick();
        chk("idle_stall_req", 32'(mem_req), 32'd0);
        branch_taken = 1'b1;
        branch_target = 32'h20;
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
        chk("idle_br_req", 32'(mem_req), 32'd1);
        chk("idle_br_addr", mem_addr, 32'h20);
        tick(); tick(); tick(); tick();
        chk("idle_br_pc", pc_output, 32'h20);
        chk("idle_br_inst", inst_output, word_at(32'h20));

        // Loop 0..12 twice
        branch_taken = 1'b1;
        branch_target = 32'd0;
        tick();
        branch_taken = 1'b0;
        for (int n = 0; n < 4; n++) begin
            wait_valid("pass1_timeout");
            chk("pass1_pc", pc_output, 32'(4 * n));
            chk("pass1_inst", inst_output, word_at(32'(4 * n)));
            if (n == 3) begin
                branch_taken = 1'b1;
                branch_target = 32'd0;
            end
            tick();
            branch_taken = 1'b0;
        end
        for (int n = 0; n < 4; n++) begin
`ifdef ICACHE_EN
            chk("pass2_hit_req", 32'(mem_req), 32'd0);
            chk("pass2_hit_valid", 32'(inst_valid), 32'd0);
            tick();
            chk("pass2_done_valid", 32'(inst_valid), 32'd1);
            chk("pass2_done_req", 32'(mem_req), 32'd0);
`else
            chk("pass2_req", 32'(mem_req), 32'd1);
            chk("pass2_addr", mem_addr, 32'(4 * n));
            wait_valid("pass2_timeout");
`endif
            chk("pass2_pc", pc_output, 32'(4 * n));
            chk("pass2_inst", inst_output, word_at(32'(4 * n)));
            tick();
        end

        // Randomized traffic against the expected-PC model
        rst = 1'b0;
        #1;
        @(negedge clk);
        rst = 1'b1;
        exp_pc = 32'd0;
        deliveries = 0;
        for (int c = 0; c < 3000; c++) begin
            stall = ($urandom_range(0, 9) < 3);
            mem_ready = ($urandom_range(0, 9) < 7);
            branch_taken = ($urandom_range(0, 99) < 5);
            branch_target = $urandom;
            v = inst_valid;
            s = stall;
            b = branch_taken;
            t = branch_target;
            tick();
            if (b) exp_pc = {t[31:2], 2'b00};
            else if (v && !s) exp_pc = exp_pc + 32'd4;
            chk("rand_busy", 32'(if_busy), 32'(!inst_valid));
            if (inst_valid) begin
                deliveries++;
                chk("rand_pc", pc_output, exp_pc);
                chk("rand_inst", inst_output, word_at(exp_pc));
            end
            if (mem_req) chk("rand_addr_word", {mem_addr[31:2], 2'b00}, exp_pc);
        end
        branch_taken = 1'b0;
        stall = 1'b0;
        chk("rand_deliveries", 32'(deliveries > 50), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
